// File: rtl/vending_pkg.sv
// Shared vending-machine definitions: key indices, key arbiter state encoding
// and the default post-event cool-down length.
package vending_pkg;

    localparam int KEY_COIN1   = 0;
    localparam int KEY_COIN5   = 1;
    localparam int KEY_SEL0    = 2;
    localparam int KEY_SEL1    = 3;
    localparam int KEY_SEL2    = 4;
    localparam int KEY_SEL3    = 5;
    localparam int KEY_CONFIRM = 6;
    localparam int KEY_CANCEL  = 7;

    localparam int DEFAULT_HOLDOFF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        COOL  = 2'd2
    } key_arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: rotates the request vector so that index ptr lands on
// bit 0, then returns the first set request at or after ptr (wrapping).
module rr_pick #(
    parameter int N_KEYS = 8,
    parameter int IDX_W  = $clog2(N_KEYS)
) (
    input  logic [N_KEYS-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic              any
);

    logic [N_KEYS-1:0] w_rot;
    logic [IDX_W:0]    w_sum;

    assign w_rot = N_KEYS'({req, req} >> ptr);

    // Descending scan so the smallest offset from ptr is the last to write.
    always_comb begin
        w_sum = '0;
        any   = 1'b0;
        for (int k = N_KEYS - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = {1'b0, ptr} + (IDX_W + 1)'(k);
                if (w_sum >= (IDX_W + 1)'(N_KEYS)) begin
                    w_sum = w_sum - (IDX_W + 1)'(N_KEYS);
                end
                any = 1'b1;
            end
        end
        gnt_idx = w_sum[IDX_W-1:0];
    end

endmodule

// File: rtl/key_event_arbiter.sv
// Serialises key pulses into one valid/ready event stream, round-robin, with a
// cool-down after each accepted event. KEY_ARB_DROP_CNT_EN adds a duplicate-pulse counter.
module key_event_arbiter
    import vending_pkg::*;
#(
    parameter  int N_KEYS  = 8,
    parameter  int HOLDOFF = DEFAULT_HOLDOFF,
    localparam int IDX_W   = $clog2(N_KEYS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_pulse,
    input  logic              enable,
    output logic              evt_valid,
    output logic [IDX_W-1:0]  evt_key,
    input  logic              evt_ready,
    output logic              busy
`ifdef KEY_ARB_DROP_CNT_EN
    ,
    output logic [7:0]        drop_cnt
`endif
);

    localparam int CNT_W = (HOLDOFF > 2) ? $clog2(HOLDOFF) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (HOLDOFF > 0) ? CNT_W'(HOLDOFF - 1) : '0;

    key_arb_state_t    r_state;
    key_arb_state_t    w_state_nxt;
    logic [N_KEYS-1:0] r_pend;
    logic [N_KEYS-1:0] w_pend_nxt;
    logic [N_KEYS-1:0] w_sel;
    logic [N_KEYS-1:0] w_clr;
    logic [N_KEYS-1:0] w_keep;
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_evt_key;
    logic [IDX_W-1:0]  w_gnt_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_any;
    logic              w_hs;
    logic              r_busy;

    rr_pick #(
        .N_KEYS (N_KEYS),
        .IDX_W  (IDX_W)
    ) u_rr_pick (
        .req     (r_pend),
        .ptr     (r_ptr),
        .gnt_idx (w_gnt_idx),
        .any     (w_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (w_any && enable) w_state_nxt = OFFER;
            OFFER: if (evt_ready) w_state_nxt = (HOLDOFF == 0) ? IDLE : COOL;
            COOL:  if (r_cnt == '0) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        evt_valid = 1'b0;
        if (r_state == OFFER) begin
            evt_valid = 1'b1;
        end
    end

    assign w_hs    = evt_valid && evt_ready;
    assign w_sel   = {{(N_KEYS - 1){1'b0}}, 1'b1} << r_evt_key;
    assign w_clr   = w_hs ? w_sel : '0;
    // With enable low only the bit of the event already on offer survives.
    assign w_keep  = enable ? ~w_clr : ((r_state == OFFER) ? (w_sel & ~w_clr) : '0);
    assign w_pend_nxt = (r_pend & w_keep) | (key_pulse & {N_KEYS{enable}});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend    <= '0;
            r_ptr     <= '0;
            r_evt_key <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            r_busy <= (r_state != IDLE) || (|r_pend);
            if (r_state == IDLE && w_state_nxt == OFFER) begin
                r_evt_key <= w_gnt_idx;
            end
            if (w_hs) begin
                r_ptr <= (r_evt_key == IDX_W'(N_KEYS - 1)) ? '0 : r_evt_key + 1'b1;
                r_cnt <= CNT_LOAD;
            end else if (r_state == COOL && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign evt_key = r_evt_key;
    assign busy    = r_busy;

`ifdef KEY_ARB_DROP_CNT_EN
    logic [7:0] r_drop;
    logic       w_dup;

    assign w_dup = enable && (|(key_pulse & r_pend & ~w_clr));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drop <= '0;
        end else if (w_dup && r_drop != 8'hFF) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    assign drop_cnt = r_drop;
`endif

endmodule

// File: tb/tb_key_event_arbiter.sv
// Scoreboard bench for key_event_arbiter: one instance with the default
// cool-down, one with HOLDOFF = 0.
module tb_key_event_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] kp_h, kp_z;
    logic       en_h, en_z, rdy_h, rdy_z;
    logic       vld_h, vld_z, busy_h, busy_z;
    logic [2:0] key_h, key_z;
`ifdef KEY_ARB_DROP_CNT_EN
    logic [7:0] drop_h, drop_z;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic rst_q = 1'b0;
    int q_h[$];
    int q_z[$];
    int hsq_z[$];
    int hs_h = -1;
    logic       stall_h = 1'b0, stall_z = 1'b0;
    logic [2:0] pkey_h = '0, pkey_z = '0;

    always #5 clk = ~clk;

    key_event_arbiter #(.N_KEYS(8), .HOLDOFF(16)) dut_h (
        .clk(clk), .rst_n(rst_n), .key_pulse(kp_h), .enable(en_h),
        .evt_valid(vld_h), .evt_key(key_h), .evt_ready(rdy_h), .busy(busy_h)
`ifdef KEY_ARB_DROP_CNT_EN
        , .drop_cnt(drop_h)
`endif
    );

    key_event_arbiter #(.N_KEYS(8), .HOLDOFF(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .key_pulse(kp_z), .enable(en_z),
        .evt_valid(vld_z), .evt_key(key_z), .evt_ready(rdy_z), .busy(busy_z)
`ifdef KEY_ARB_DROP_CNT_EN
        , .drop_cnt(drop_z)
`endif
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Called just after a rising edge; holds mask for n sampling edges.
    task automatic pulse(input bit z, input logic [7:0] m, input int n);
        if (z) kp_z = m; else kp_h = m;
        repeat (n) @(posedge clk);
        #1;
        if (z) kp_z = '0; else kp_h = '0;
    endtask

    task automatic wait_vld(input bit z, input int budget, output int c);
        c = -1000;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (z ? vld_z : vld_h) begin
                c = cyc;
                break;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        cyc++;
        rst_q = rst_n;
    end

    always @(negedge clk) begin
        if (rst_q && stall_h) begin
            chk("h_hold_vld", vld_h, 1);
            chk("h_hold_key", key_h, pkey_h);
        end
        stall_h = rst_n && vld_h && !rdy_h;
        pkey_h  = key_h;
        if (rst_n && vld_h && rdy_h) begin
            hs_h = cyc;
            if (q_h.size() == 0) chk("h_unexpected_key", key_h, -1);
            else chk("h_key", key_h, q_h.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_q && stall_z) begin
            chk("z_hold_vld", vld_z, 1);
            chk("z_hold_key", key_z, pkey_z);
        end
        stall_z = rst_n && vld_z && !rdy_z;
        pkey_z  = key_z;
        if (rst_n && vld_z && rdy_z) begin
            hsq_z.push_back(cyc);
            if (q_z.size() == 0) chk("z_unexpected_key", key_z, -1);
            else chk("z_key", key_z, q_z.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, c, h;
        rst_n = 1'b0; kp_h = '0; kp_z = '0;
        en_h = 1'b1; en_z = 1'b1; rdy_h = 1'b1; rdy_z = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", vld_h, 0);
        chk("rst_key", key_h, 0);
        chk("rst_busy", busy_h, 0);
        chk("rst_vld_z", vld_z, 0);
`ifdef KEY_ARB_DROP_CNT_EN
        chk("rst_drop", drop_h, 0);
`endif
        step();
        rst_n = 1'b1;

        // single key 3, ready high, default cool-down
        q_h.push_back(3);
        pulse(0, 8'h08, 1);
        t = cyc;
        chk("t1_pend", dut_h.r_pend, 8'h08);
        wait_vld(0, 10, c);
        chk("t1_lat", c - t, 1);
        chk("t1_key", key_h, 3);
        step();
        h = cyc;
        chk("t1_ptr", dut_h.r_ptr, 4);
        q_h.push_back(5);
        pulse(0, 8'h20, 1);
        chk("t1_busy", busy_h, 1);
        wait_vld(0, 40, c);
        chk("t1_cool", c - h, 17);
        step();

        // key 7 stalled for ten cycles
        repeat (20) step();
        rdy_h = 1'b0;
        q_h.push_back(7);
        pulse(0, 8'h80, 1);
        wait_vld(0, 10, c);
        chk("t3_key", key_h, 7);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_vld", vld_h, 1);
            chk("t3_key_hold", key_h, 7);
        end
        step();
        rdy_h = 1'b1;
        @(negedge clk);
        step();
        chk("t3_hs", hs_h, cyc - 1);
        chk("t3_vld_low", vld_h, 0);

`ifdef KEY_ARB_DROP_CNT_EN
        repeat (20) step();
        rdy_h = 1'b0;
        q_h.push_back(2);
        pulse(0, 8'h04, 1);
        wait_vld(0, 10, c);
        chk("drop_key", key_h, 2);
        step();
        for (int i = 0; i < 3; i++) begin
            pulse(0, 8'h04, 1);
            step();
        end
        chk("drop3", drop_h, 3);
        pulse(0, 8'h04, 297);
        chk("drop_sat", drop_h, 255);
        rdy_h = 1'b1;
        step();
        step();
`endif

        // enable low while key 4 offered and key 5 pending
        repeat (20) step();
        rdy_h = 1'b0;
        q_h.push_back(4);
        pulse(0, 8'h30, 1);
        wait_vld(0, 10, c);
        chk("t5_key", key_h, 4);
        step();
        en_h = 1'b0;
        pulse(0, 8'h02, 1);
        chk("t5_pend_keep", dut_h.r_pend, 8'h10);
        rdy_h = 1'b1;
        step();
        chk("t5_pend_flush", dut_h.r_pend, 0);
        pulse(0, 8'h40, 1);
        wait_vld(0, 30, c);
        chk("t5_quiet", c, -1000);
        chk("t5_busy", busy_h, 0);
        step();
        en_h = 1'b1;
        q_h.push_back(6);
        pulse(0, 8'h40, 1);
        wait_vld(0, 10, c);
        chk("t5_resume", key_h, 6);
        step();

        // reset mid-OFFER
        repeat (20) step();
        rdy_h = 1'b0;
        pulse(0, 8'h0A, 1);
        wait_vld(0, 10, c);
        chk("t6_key", key_h, 1);
        step();
        rst_n = 1'b0;
        q_h.delete();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_vld", vld_h, 0);
        chk("t6_pend", dut_h.r_pend, 0);
        chk("t6_ptr", dut_h.r_ptr, 0);
        chk("t6_key_rst", key_h, 0);
`ifdef KEY_ARB_DROP_CNT_EN
        chk("t6_drop", drop_h, 0);
`endif
        rdy_h = 1'b1;
        step();

        // HOLDOFF = 0: keys 1,5,6 together, then 0 and 6 across the wrap
        q_z.push_back(1); q_z.push_back(5); q_z.push_back(6);
        pulse(1, 8'h62, 1);
        t = cyc;
        repeat (12) step();
        chk("t2_count", hsq_z.size(), 3);
        if (hsq_z.size() >= 3) begin
            chk("t2_first", hsq_z[0] + 1 - t, 2);
            chk("t2_gap1", hsq_z[1] - hsq_z[0], 2);
            chk("t2_gap2", hsq_z[2] - hsq_z[1], 2);
        end
        chk("t2_ptr", dut_z.r_ptr, 7);
        q_z.push_back(0); q_z.push_back(6);
        pulse(1, 8'h41, 1);
        repeat (10) step();
        chk("t2_drain", q_z.size(), 0);
        chk("t2_ptr_end", dut_z.r_ptr, 7);
        chk("h_drain", q_h.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
